icache: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 29 ++
 rtl/icache.sv | 102 ++++++++++
 tb/tb_icache.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction cache address split, frame layout and fill FSM states.
package cpu_types_pkg;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    logic [31:0]             data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hits, one blocking
// word read to the memory controller per miss, then the frame is filled.
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(SETS);

  // Frame and address structs are sized by the package, so the geometry must agree.
  generate
    if (IDX_W != ICACHE_IDX_W) begin : g_bad_sets
      $error("icache: SETS must match cpu_types_pkg::ICACHE_SETS");
    end
  endgenerate

  icache_state_t state_q, state_d;
  logic [31:0]   miss_addr_q, miss_addr_d;
  logic [31:0]   iaddr_q, iaddr_d;
  logic          iren_q, iren_d;

  icache_frame_t frames_q [SETS];
  icachef_t      req, fill;
  icache_frame_t req_frame, fill_frame;
  logic          lookup_hit, fill_we;

  assign req       = icachef_t'(imemaddr);
  assign fill      = icachef_t'(miss_addr_q);
  assign req_frame = frames_q[req.idx];

  assign lookup_hit = imemREN && req_frame.valid && (req_frame.tag == req.tag);
  assign ihit       = lookup_hit && (state_q == IDLE);
  assign imemload   = ihit ? req_frame.data : 32'h0;
  assign iREN       = iren_q;
  assign iaddr      = iaddr_q;

  always_comb begin
    state_d          = state_q;
    miss_addr_d      = miss_addr_q;
    iren_d           = iren_q;
    iaddr_d          = iaddr_q;
    fill_we          = 1'b0;
    fill_frame.valid = 1'b1;
    fill_frame.tag   = fill.tag;
    fill_frame.data  = iload;
    case (state_q)
      IDLE: begin
        if (imemREN && !lookup_hit) begin
          miss_addr_d = word_align(imemaddr);
          iaddr_d     = word_align(imemaddr);
          iren_d      = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Completes even if the fetch stage withdrew; the controller is mid-transfer.
        if (!iwait) begin
          fill_we = 1'b1;
          iren_d  = 1'b0;
          iaddr_d = 32'h0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= 32'h0;
      iren_q      <= 1'b0;
      iaddr_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      iren_q      <= iren_d;
      iaddr_q     <= iaddr_d;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < SETS; i++) frames_q[i] <= '0;
    end else if (fill_we) begin
      frames_q[fill.idx] <= fill_frame;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, multi-cycle corner sequences and
// randomized fetches compared against an abstract cache/controller model.
module tb_icache;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Model: which word address each index holds, and an outstanding fill if any.
  bit          m_valid [16];
  logic [31:0] m_word  [16];
  bit          m_fill;
  logic [31:0] m_pend;
  int          m_cnt, m_lat;
  int          lat_cfg = 3;
  bit          lat_rand = 1'b0;

  logic        e_ihit, e_iren;
  logic [31:0] e_load, e_iaddr;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        ihit;
    logic [31:0] load;
    logic        iren;
    logic [31:0] iaddr;
  } vec_t;
  vec_t vt [7];

  function automatic logic [31:0] ram(input logic [31:0] w);
    if (w == 32'h4)  return 32'h2402_0001;
    if (w == 32'h40) return 32'hAAAA_AAAA;
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return (a / 4) % 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_fill = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr);
    logic [31:0] w;
    w        = addr & ~32'h3;
    imemREN  = ren;
    imemaddr = addr;
    e_ihit   = !m_fill && ren && m_valid[idx_of(w)] && (m_word[idx_of(w)] == w);
    e_load   = e_ihit ? ram(w) : 32'h0;
    e_iren   = m_fill;
    e_iaddr  = m_fill ? m_pend : 32'h0;
    if (m_fill && m_cnt == m_lat - 1) begin
      iwait = 1'b0;
      iload = ram(m_pend);
    end else begin
      iwait = 1'b1;
      iload = $urandom;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".ihit"},     {31'h0, ihit}, {31'h0, e_ihit});
    check({tag, ".imemload"}, imemload,      e_load);
    check({tag, ".iREN"},     {31'h0, iREN}, {31'h0, e_iren});
    check({tag, ".iaddr"},    iaddr,         e_iaddr);
  endtask

  task automatic advance();
    @(posedge CLK);
    if (m_fill) begin
      if (m_cnt == m_lat - 1) begin
        m_valid[idx_of(m_pend)] = 1'b1;
        m_word[idx_of(m_pend)]  = m_pend;
        m_fill = 1'b0;
      end else begin
        m_cnt++;
      end
    end else if (imemREN && !e_ihit) begin
      m_fill = 1'b1;
      m_pend = imemaddr & ~32'h3;
      m_cnt  = 0;
      m_lat  = lat_rand ? int'($urandom_range(1, 4)) : lat_cfg;
    end
    #1;
  endtask

  task automatic cycle(input logic ren, input logic [31:0] addr, input string tag);
    drive(ren, addr);
    check_model(tag);
    advance();
  endtask

  // Fetch until the model predicts a hit; returns cycles spent (1 = immediate hit).
  task automatic fetch(input logic [31:0] addr, input string tag, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      drive(1'b1, addr);
      check_model(tag);
      done = e_ihit;
      cycles++;
      advance();
    end
    if (!done) check({tag, ".timeout"}, 32'h0, 32'h1);
  endtask

  task automatic do_reset();
    nRST    = 1'b0;
    imemREN = 1'b0;
    iwait   = 1'b1;
    #1;
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  initial begin
    int cyc, misses, hits;
    imemREN  = 1'b0;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;
    nRST     = 1'b0;
    model_reset();
    #2;
    check("reset.ihit",     {31'h0, ihit}, 32'h0);
    check("reset.imemload", imemload,      32'h0);
    check("reset.iREN",     {31'h0, iREN}, 32'h0);
    check("reset.iaddr",    iaddr,         32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss with a 3-cycle fill, then hit, then offset-ignored hit.
    vt[0] = '{1'b1, 32'h4, 1'b0, 32'h0,          1'b0, 32'h0};
    vt[1] = '{1'b1, 32'h4, 1'b0, 32'h0,          1'b1, 32'h4};
    vt[2] = '{1'b1, 32'h4, 1'b0, 32'h0,          1'b1, 32'h4};
    vt[3] = '{1'b1, 32'h4, 1'b0, 32'h0,          1'b1, 32'h4};
    vt[4] = '{1'b1, 32'h4, 1'b1, 32'h2402_0001,  1'b0, 32'h0};
    vt[5] = '{1'b1, 32'h7, 1'b1, 32'h2402_0001,  1'b0, 32'h0};
    vt[6] = '{1'b0, 32'h4, 1'b0, 32'h0,          1'b0, 32'h0};
    lat_cfg = 3;
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].ren, vt[i].addr);
      check($sformatf("vec%0d.ihit", i),     {31'h0, ihit}, {31'h0, vt[i].ihit});
      check($sformatf("vec%0d.imemload", i), imemload,      vt[i].load);
      check($sformatf("vec%0d.iREN", i),     {31'h0, iREN}, {31'h0, vt[i].iren});
      check($sformatf("vec%0d.iaddr", i),    iaddr,         vt[i].iaddr);
      advance();
    end

    // Conflict eviction on index 0.
    lat_cfg = 2;
    fetch(32'h40, "conf.fill40", cyc);
    drive(1'b1, 32'h40);
    check("conf.hit40", imemload, 32'hAAAA_AAAA);
    advance();
    drive(1'b1, 32'h80);
    check("conf.miss80", {31'h0, ihit}, 32'h0);
    advance();
    drive(1'b1, 32'h80);
    check("conf.iaddr80", iaddr, 32'h80);
    check("conf.iren80", {31'h0, iREN}, 32'h1);
    advance();
    fetch(32'h80, "conf.fill80", cyc);
    drive(1'b1, 32'h40);
    check("conf.evict40", {31'h0, ihit}, 32'h0);
    check_model("conf.evict40m");
    advance();
    fetch(32'h40, "conf.refill40", cyc);

    // Request withdrawn and address changed mid-fill.
    lat_cfg = 4;
    cycle(1'b1, 32'h8, "wd.start");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h100);
      check("wd.iaddr", iaddr, 32'h8);
      check_model("wd.fill");
      advance();
    end
    drive(1'b1, 32'h100);
    check("wd.miss100", {31'h0, ihit}, 32'h0);
    check_model("wd.miss100m");
    advance();
    drive(1'b1, 32'h100);
    check("wd.iaddr100", iaddr, 32'h100);
    advance();
    fetch(32'h100, "wd.fill100", cyc);
    drive(1'b1, 32'h8);
    check("wd.hit8", imemload, ram(32'h8));
    advance();

    // Reset in the middle of a fill.
    lat_cfg = 1000;
    cycle(1'b1, 32'hC, "rst.start");
    drive(1'b1, 32'hC);
    check("rst.fill_iren", {31'h0, iREN}, 32'h1);
    nRST = 1'b0;
    #1;
    check("rst.async_iren",  {31'h0, iREN}, 32'h0);
    check("rst.async_iaddr", iaddr,         32'h0);
    check("rst.async_ihit",  {31'h0, ihit}, 32'h0);
    model_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    lat_cfg = 2;
    drive(1'b1, 32'h4);
    check("rst.cold4", {31'h0, ihit}, 32'h0);
    check_model("rst.cold4m");
    advance();
    fetch(32'h4, "rst.fill4", cyc);

    // Sweep of all sixteen frames, twice.
    do_reset();
    lat_rand = 1'b1;
    misses = 0;
    for (int a = 0; a < 16; a++) begin
      fetch(32'(a * 4), "sweep1", cyc);
      if (cyc > 1) misses++;
    end
    check("sweep1.misses", misses, 16);
    hits = 0;
    for (int a = 0; a < 16; a++) begin
      fetch(32'(a * 4), "sweep2", cyc);
      if (cyc == 1) hits++;
    end
    check("sweep2.hits", hits, 16);

    // Random fetches over a small address pool so hits, conflicts and withdrawals mix.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ra;
      ra = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
         | 32'($urandom_range(0, 3));
      cycle($urandom_range(0, 3) != 0, ra, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
